// File: rtl/posit_encoder.sv
// -----------------------------------------------------------------------------
// posit_encoder
//   Sequential posit<N,ES> encoder. Packs a decoded value
//   (sign, scale, fraction, zero/NaR flags) into an N-bit posit, rounding to
//   nearest with ties to even. The body (everything below the sign bit) is
//   built serially, one bit per cycle, MSB first: regime, exponent, fraction.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : input word valid
//   in_ready      : encoder idle and able to accept a word
//   in_sign       : 1 = negative
//   in_zero       : value is exactly zero (overrides scale/frac)
//   in_nar        : value is NaR (overrides in_zero)
//   in_scale[SW]  : signed power of two, value = (1 + frac) * 2^scale
//   in_frac[FW]   : fraction bits below the hidden 1, MSB weight 2^-1
//   out_valid     : out_posit holds a result
//   out_ready     : consumer takes the result
//   out_posit[N]  : encoded posit
//   out_inexact   : (POSIT_ENC_STATUS_EN only) guard|sticky were nonzero
//   out_sat       : (POSIT_ENC_STATUS_EN only) saturation or clamp occurred
//
// Build option
//   POSIT_ENC_STATUS_EN : when defined, adds out_inexact and out_sat.
// -----------------------------------------------------------------------------
module posit_encoder #(
  parameter int N  = 16,
  parameter int ES = 3,
  parameter int FW = 16,
  parameter int SW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
`ifdef POSIT_ENC_STATUS_EN
  ,
  output logic          out_inexact,
  output logic          out_sat
`endif
);

  localparam int BW = N - 1;           // body width (posit without sign)
  localparam int TW = ES + FW;         // exponent + fraction tail
  localparam int CW = $clog2(N) + 1;   // counter / run-length width

  localparam logic signed [SW-1:0] K_HI     = SW'(N - 2);
  localparam logic signed [SW-1:0] K_LO     = SW'(1 - N);
  localparam logic [CW-1:0]        CNT_LAST = CW'(BW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t         state_q,     state_d;
  logic           sign_q,      sign_d;
  logic           sat_q,       sat_d;
  logic           rbit_q,      rbit_d;     // value of the regime run bits
  logic           term_q,      term_d;     // regime terminator already emitted
  logic [CW-1:0]  run_q,       run_d;      // regime run bits still to emit
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [TW-1:0]  tail_q,      tail_d;     // {e, frac}, shifted out MSB first
  logic [BW-1:0]  body_q,      body_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_posit_q, out_posit_d;
`ifdef POSIT_ENC_STATUS_EN
  logic           inexact_q,   inexact_d;
  logic           osat_q,      osat_d;
`endif

  // Regime index k = floor(scale / 2^ES); low ES bits are the exponent field.
  logic signed [SW-1:0] k_s;
  logic [CW-1:0]        k_lo;
  assign k_s  = $signed(in_scale) >>> ES;
  assign k_lo = k_s[CW-1:0];

  // Rounding datapath. After N-1 shifts the tail MSB is the guard bit and
  // everything below it (including never-emitted fraction) is sticky.
  logic          guard;
  logic          sticky;
  logic          round_up;
  logic [N-1:0]  sum;
  logic          clamp;
  logic [N-1:0]  mag;
  assign guard    = tail_q[TW-1];
  assign sticky   = |tail_q[TW-2:0];
  assign round_up = guard & (sticky | body_q[0]);
  assign sum      = {1'b0, body_q} + {{(N-1){1'b0}}, round_up};
  // A carry out of the body would reach the sign bit: hold at maxpos instead.
  assign clamp    = sum[N-1];
  assign mag      = clamp ? {1'b0, {BW{1'b1}}} : sum;

  logic body_bit;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    rbit_d      = rbit_q;
    term_d      = term_q;
    run_d       = run_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    body_d      = body_q;
    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
`ifdef POSIT_ENC_STATUS_EN
    inexact_d   = inexact_q;
    osat_d      = osat_q;
`endif
    body_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_nar) begin
            out_posit_d = {1'b1, {(N-1){1'b0}}};
            out_valid_d = 1'b1;
            state_d     = DONE;
`ifdef POSIT_ENC_STATUS_EN
            inexact_d   = 1'b0;
            osat_d      = 1'b0;
`endif
          end else if (in_zero) begin
            out_posit_d = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
`ifdef POSIT_ENC_STATUS_EN
            inexact_d   = 1'b0;
            osat_d      = 1'b0;
`endif
          end else begin
            sign_d  = in_sign;
            cnt_d   = '0;
            term_d  = 1'b0;
            rbit_d  = ~k_s[SW-1];
            // k >= 0: k+1 ones then 0; k < 0: -k zeros then 1.
            run_d   = k_s[SW-1] ? (~k_lo + CW'(1)) : (k_lo + CW'(1));
            state_d = SHIFT;
            if (k_s >= K_HI) begin
              // Saturated body is preloaded; the SHIFT phase only counts,
              // and a cleared tail keeps guard/sticky at zero.
              sat_d  = 1'b1;
              body_d = {BW{1'b1}};
              tail_d = '0;
            end else if (k_s <= K_LO) begin
              sat_d  = 1'b1;
              body_d = {{(BW-1){1'b0}}, 1'b1};
              tail_d = '0;
            end else begin
              sat_d  = 1'b0;
              body_d = '0;
              tail_d = {in_scale[ES-1:0], in_frac};
            end
          end
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (!sat_q) begin
          if (run_q != '0) begin
            body_bit = rbit_q;
            run_d    = run_q - CW'(1);
          end else if (!term_q) begin
            body_bit = ~rbit_q;
            term_d   = 1'b1;
          end else begin
            body_bit = tail_q[TW-1];
            tail_d   = {tail_q[TW-2:0], 1'b0};
          end
          body_d = {body_q[BW-2:0], body_bit};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        out_posit_d = sign_q ? (~mag + N'(1)) : mag;
        out_valid_d = 1'b1;
        state_d     = DONE;
`ifdef POSIT_ENC_STATUS_EN
        inexact_d   = guard | sticky;
        osat_d      = sat_q | clamp;
`endif
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      rbit_q      <= 1'b0;
      term_q      <= 1'b0;
      run_q       <= '0;
      cnt_q       <= '0;
      tail_q      <= '0;
      body_q      <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
`ifdef POSIT_ENC_STATUS_EN
      inexact_q   <= 1'b0;
      osat_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      rbit_q      <= rbit_d;
      term_q      <= term_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      body_q      <= body_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
`ifdef POSIT_ENC_STATUS_EN
      inexact_q   <= inexact_d;
      osat_q      <= osat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
`ifdef POSIT_ENC_STATUS_EN
  assign out_inexact = inexact_q;
  assign out_sat     = osat_q;
`endif

endmodule
